// File: rtl/gf_pkg.sv
// GF(2^8) arithmetic and Reed-Solomon code constants.
//
// Shared by the RS encoder. Holds the code geometry (symbol width, codeword
// and message lengths, number of parity roots, first consecutive root), a
// generic GF multiplier, and the monic generator polynomial
//   g(x) = prod_{i=0}^{ROOTS_NUM-1} (x - alpha^(FIRST_ROOT+i))
// computed at elaboration time. GEN_POLY[k] is the coefficient of x^k,
// so GEN_POLY[ROOTS_NUM] is always 1.
package gf_pkg;

    localparam int SYMB_WIDTH = 8;
    localparam int N_LEN      = 64;
    localparam int ROOTS_NUM  = 8;
    localparam int FIRST_ROOT = 0;
    localparam int K_LEN      = N_LEN - ROOTS_NUM;

    // x^8 + x^4 + x^3 + x^2 + 1, alpha = 0x02 is primitive
    localparam logic [SYMB_WIDTH:0] PRIM_POLY = 9'h11D;

    localparam int SYM_CNT_W = $clog2(K_LEN);
    localparam int PAR_CNT_W = $clog2(ROOTS_NUM);

    typedef logic [SYMB_WIDTH-1:0]              symb_t;
    typedef logic [ROOTS_NUM:0][SYMB_WIDTH-1:0] gen_poly_t;

    // Shift-and-add multiply; with one operand constant this collapses to
    // a fixed XOR network.
    function automatic symb_t gf_mult(input symb_t a, input symb_t b);
        symb_t prod;
        symb_t acc;
        prod = '0;
        acc  = a;
        for (int i = 0; i < SYMB_WIDTH; i++) begin
            if (b[i]) begin
                prod = prod ^ acc;
            end
            if (acc[SYMB_WIDTH-1]) begin
                acc = (acc << 1) ^ PRIM_POLY[SYMB_WIDTH-1:0];
            end else begin
                acc = acc << 1;
            end
        end
        return prod;
    endfunction

    function automatic symb_t gf_alpha_pow(input int n);
        symb_t p;
        p = symb_t'(1);
        for (int i = 0; i < n; i++) begin
            p = gf_mult(p, symb_t'(2));
        end
        return p;
    endfunction

    // Multiply out (x + root_i) one factor at a time.
    function automatic gen_poly_t calc_gen_poly(input int first_root);
        gen_poly_t g;
        symb_t     root;
        g    = '0;
        g[0] = symb_t'(1);
        for (int i = 0; i < ROOTS_NUM; i++) begin
            root = gf_alpha_pow(first_root + i);
            for (int j = ROOTS_NUM; j > 0; j--) begin
                g[j] = g[j-1] ^ gf_mult(g[j], root);
            end
            g[0] = gf_mult(g[0], root);
        end
        return g;
    endfunction

    localparam gen_poly_t GEN_POLY = calc_gen_poly(FIRST_ROOT);

endpackage

// File: rtl/rs_encoder.sv
// Systematic Reed-Solomon encoder, RS(N_LEN, K_LEN) over GF(2^8).
//
// Streams K_LEN message symbols through unchanged, then appends ROOTS_NUM
// parity symbols (remainder of m(x)*x^ROOTS_NUM mod g(x)), highest degree
// first. Framing is by symbol count; s_tlast is only checked.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_tdata/s_tvalid/
//   s_tlast/s_tready       message symbol input (AXI-Stream style)
//   m_tdata/m_tvalid/
//   m_tlast/m_tready       codeword output, single register stage
//   irq_frame_len          one-cycle pulse when s_tlast disagrees with count
module rs_encoder
    import gf_pkg::*;
(
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [SYMB_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic [SYMB_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  irq_frame_len
);

    typedef enum logic {ST_DATA, ST_PARITY} state_t;

    state_t                                 state;
    state_t                                 state_nxt;
    logic [SYM_CNT_W-1:0]                   sym_cnt;
    logic [PAR_CNT_W-1:0]                   par_cnt;
    logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0]   rem;
    logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0]   rem_nxt;
    logic                                   out_free;
    logic                                   accept;
    logic                                   par_load;
    logic                                   last_sym;
    logic                                   last_par;
    symb_t                                  fb;

    // The output register can take a new symbol when empty or draining.
    assign out_free = ~m_tvalid | m_tready;
    assign s_tready = (state == ST_DATA) & out_free;
    assign accept   = s_tvalid & s_tready;
    assign par_load = (state == ST_PARITY) & out_free;
    assign last_sym = (sym_cnt == SYM_CNT_W'(K_LEN - 1));
    assign last_par = (par_cnt == PAR_CNT_W'(ROOTS_NUM - 1));
    assign fb       = s_tdata ^ rem[ROOTS_NUM-1];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_DATA:   if (accept && last_sym)   state_nxt = ST_PARITY;
            ST_PARITY: if (par_load && last_par) state_nxt = ST_DATA;
        endcase
    end

    // Division LFSR while taking message symbols; plain shift register while
    // unloading parity, so it is back to all-zero after the last parity.
    always_comb begin
        rem_nxt = rem;
        if (accept) begin
            rem_nxt[0] = gf_mult(fb, GEN_POLY[0]);
            for (int i = 1; i < ROOTS_NUM; i++) begin
                rem_nxt[i] = rem[i-1] ^ gf_mult(fb, GEN_POLY[i]);
            end
        end else if (par_load) begin
            rem_nxt[0] = '0;
            for (int i = 1; i < ROOTS_NUM; i++) begin
                rem_nxt[i] = rem[i-1];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_DATA;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sym_cnt       <= '0;
            par_cnt       <= '0;
            irq_frame_len <= 1'b0;
        end else begin
            irq_frame_len <= 1'b0;
            if (accept) begin
                sym_cnt       <= last_sym ? '0 : sym_cnt + SYM_CNT_W'(1);
                irq_frame_len <= (s_tlast != last_sym);
            end
            if (par_load) begin
                par_cnt <= last_par ? '0 : par_cnt + PAR_CNT_W'(1);
            end
        end
    end

    // Output register: message symbols pass through, then parity from the
    // top of the remainder. Held unchanged while stalled.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end else if (accept) begin
            m_tdata  <= s_tdata;
            m_tvalid <= 1'b1;
            m_tlast  <= 1'b0;
        end else if (par_load) begin
            m_tdata  <= rem[ROOTS_NUM-1];
            m_tvalid <= 1'b1;
            m_tlast  <= last_par;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end
    end

endmodule
